// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the Y86 pipeline registers and pipe_hazard_ctrl.
//   master : pipeline side; drives stage state, receives controls/status
//   slave  : hazard unit side
//   Stage state : D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB,
//                 e_cnd, m_stat, W_stat
//   Controls    : F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc
//   Status      : halted, halt_stat, lu_cnt, ret_cnt, mp_cnt
interface pipe_hazard_ctrl_if #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 4,
  parameter int CNT_W   = 16
);
  logic [ICODE_W-1:0] D_icode;
  logic [ICODE_W-1:0] E_icode;
  logic [ICODE_W-1:0] M_icode;
  logic [REG_W-1:0]   E_dstM;
  logic [REG_W-1:0]   d_srcA;
  logic [REG_W-1:0]   d_srcB;
  logic               e_cnd;
  logic [STAT_W-1:0]  m_stat;
  logic [STAT_W-1:0]  W_stat;
  logic               F_stall;
  logic               D_stall;
  logic               W_stall;
  logic               D_bubble;
  logic               E_bubble;
  logic               M_bubble;
  logic               set_cc;
  logic               halted;
  logic [STAT_W-1:0]  halt_stat;
  logic [CNT_W-1:0]   lu_cnt;
  logic [CNT_W-1:0]   ret_cnt;
  logic [CNT_W-1:0]   mp_cnt;

  modport master (
    output D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_cnd, m_stat, W_stat,
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
    input  halted, halt_stat, lu_cnt, ret_cnt, mp_cnt
  );

  modport slave (
    input  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_cnd, m_stat, W_stat,
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc,
    output halted, halt_stat, lu_cnt, ret_cnt, mp_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit for the Y86 five-stage pipeline.
// Produces combinational stall/bubble/set_cc controls from D/E/M/W stage
// state, a sticky RUN->HALT machine entered when an exception stat reaches
// Writeback, and saturating counters for load-use, ret and mispredict events.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipe_hazard_ctrl_if slave modport (stage state in, controls/status out)
module pipe_hazard_ctrl #(
  parameter int ICODE_W   = 4,
  parameter int REG_W     = 4,
  parameter int STAT_W    = 4,
  parameter int CNT_W     = 16,
  parameter int RNONE     = 15,
  parameter int IC_OPQ    = 6,
  parameter int IC_JXX    = 7,
  parameter int IC_RET    = 9,
  parameter int IC_MRMOVQ = 5,
  parameter int IC_POPQ   = 11,
  parameter int ST_HLT    = 2,
  parameter int ST_ADR    = 3,
  parameter int ST_INS    = 4
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t             state_q, state_nxt;
  logic [STAT_W-1:0]  halt_stat_q;
  logic [CNT_W-1:0]   lu_cnt_q, ret_cnt_q, mp_cnt_q;

  logic load_use, ret_hz, mispred, m_exc, w_exc;

  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == STAT_W'(ST_HLT)) || (s == STAT_W'(ST_ADR)) || (s == STAT_W'(ST_INS));
  endfunction

  // Holds at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    load_use = ((bus.E_icode == ICODE_W'(IC_MRMOVQ)) || (bus.E_icode == ICODE_W'(IC_POPQ)))
               && (bus.E_dstM != REG_W'(RNONE))
               && ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    ret_hz   = (bus.D_icode == ICODE_W'(IC_RET)) || (bus.E_icode == ICODE_W'(IC_RET))
               || (bus.M_icode == ICODE_W'(IC_RET));
    mispred  = (bus.E_icode == ICODE_W'(IC_JXX)) && !bus.e_cnd;
    m_exc    = is_exc(bus.m_stat);
    w_exc    = is_exc(bus.W_stat);
  end

  // Next state and controls; reset overrides everything, HALT freezes the pipe.
  always_comb begin
    state_nxt    = state_q;
    bus.F_stall  = 1'b0;
    bus.D_stall  = 1'b0;
    bus.W_stall  = 1'b0;
    bus.D_bubble = 1'b0;
    bus.E_bubble = 1'b0;
    bus.M_bubble = 1'b0;
    bus.set_cc   = 1'b0;
    if (reset) begin
      bus.D_bubble = 1'b1;
      bus.E_bubble = 1'b1;
      bus.M_bubble = 1'b1;
    end else if (state_q == HALT) begin
      bus.F_stall  = 1'b1;
      bus.D_stall  = 1'b1;
      bus.W_stall  = 1'b1;
      bus.M_bubble = 1'b1;
    end else begin
      if (w_exc) state_nxt = HALT;
      bus.F_stall  = load_use | ret_hz;
      bus.D_stall  = load_use;
      // A load-use stall in D takes priority over the ret bubble.
      bus.D_bubble = mispred | (!load_use & ret_hz);
      bus.E_bubble = mispred | load_use;
      bus.M_bubble = m_exc | w_exc;
      bus.W_stall  = w_exc;
      bus.set_cc   = (bus.E_icode == ICODE_W'(IC_OPQ)) & !m_exc & !w_exc;
    end
  end

  // State, halt status and counters; counters still count on the halting edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      halt_stat_q <= '0;
      lu_cnt_q    <= '0;
      ret_cnt_q   <= '0;
      mp_cnt_q    <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == RUN) begin
        if (w_exc)               halt_stat_q <= bus.W_stat;
        if (load_use)            lu_cnt_q    <= sat_inc(lu_cnt_q);
        if (ret_hz && !load_use) ret_cnt_q   <= sat_inc(ret_cnt_q);
        if (mispred)             mp_cnt_q    <= sat_inc(mp_cnt_q);
      end
    end
  end

  assign bus.halted    = (state_q == HALT);
  assign bus.halt_stat = halt_stat_q;
  assign bus.lu_cnt    = lu_cnt_q;
  assign bus.ret_cnt   = ret_cnt_q;
  assign bus.mp_cnt    = mp_cnt_q;

endmodule
